// File: rtl/gate_sweep_ctrl.sv
// Sweeps a 2-input gate through vectors 00,01,10,11, samples its output after a
// programmable settle time and reports pass, per-vector error mask and error count.
module gate_sweep_ctrl #(
  parameter logic [3:0]  TRUTH  = 4'b0111,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_y,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask,
  output logic [2:0] err_count,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(SETTLE - 1);

  state_t     r_state;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic       r_gate_a;
  logic       r_gate_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_err_mask;
  logic [2:0] r_err_count;

  logic       w_mis;
  logic [1:0] w_idx_inc;
  logic [3:0] w_mask_nxt;
  logic [2:0] w_count_nxt;

  // Case-inequality so an unknown gate output is flagged as a mismatch in simulation.
  always_comb begin
    w_mis       = (gate_y !== TRUTH[r_idx]);
    w_idx_inc   = r_idx + 2'd1;
    w_mask_nxt  = r_err_mask | (w_mis ? (4'b0001 << r_idx) : 4'b0000);
    w_count_nxt = r_err_count + {2'b00, w_mis};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= 4'd0;
      r_gate_a    <= 1'b0;
      r_gate_b    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_mask  <= 4'b0000;
      r_err_count <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx       <= 2'd0;
            r_cnt       <= LP_CNT_INIT;
            r_gate_a    <= 1'b0;
            r_gate_b    <= 1'b0;
            r_err_mask  <= 4'b0000;
            r_err_count <= 3'd0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_err_mask  <= w_mask_nxt;
            r_err_count <= w_count_nxt;
            if (r_idx != 2'd3) begin
              r_idx    <= w_idx_inc;
              r_gate_a <= w_idx_inc[1];
              r_gate_b <= w_idx_inc[0];
              r_cnt    <= LP_CNT_INIT;
            end else begin
              // Last vector: pass must include this sample's result.
              r_gate_a <= 1'b0;
              r_gate_b <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_pass   <= (w_count_nxt == 3'd0);
              r_state  <= FIN;
            end
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gate_a    = r_gate_a;
  assign gate_b    = r_gate_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_mask  = r_err_mask;
  assign err_count = r_err_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: table vectors, random gate behaviours
// against a truth-table model, and hand-written reset/delay/held-start sequences.
module tb_gate_sweep_ctrl;

  localparam logic [3:0] TT_NAND = 4'b0111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT 1: SETTLE=1, gate driven by a selectable behaviour
  logic       start1, gate_y1, gate_a1, gate_b1, busy1, done1, pass1;
  logic [3:0] err_mask1;
  logic [2:0] err_count1;
  logic [1:0] dbg_state1;

  // DUT 2: SETTLE=3, gate is a NAND whose output lags by two clocks
  logic       start2, gate_y2, gate_a2, gate_b2, busy2, done2, pass2;
  logic [3:0] err_mask2;
  logic [2:0] err_count2;
  logic [1:0] dbg_state2;

  gate_sweep_ctrl #(.TRUTH(TT_NAND), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .gate_y(gate_y1),
    .gate_a(gate_a1), .gate_b(gate_b1), .busy(busy1), .done(done1),
    .pass(pass1), .err_mask(err_mask1), .err_count(err_count1),
    .dbg_state(dbg_state1)
  );

  gate_sweep_ctrl #(.TRUTH(TT_NAND), .SETTLE(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .gate_y(gate_y2),
    .gate_a(gate_a2), .gate_b(gate_b2), .busy(busy2), .done(done2),
    .pass(pass2), .err_mask(err_mask2), .err_count(err_count2),
    .dbg_state(dbg_state2)
  );

  // ---------------- gate models ----------------
  logic [3:0] r_tt;
  logic       r_dly;
  logic       d1_q1, d1_q2, d2_q1, d2_q2;

  always @(posedge clk) begin
    d1_q1 <= ~(gate_a1 & gate_b1);
    d1_q2 <= d1_q1;
    d2_q1 <= ~(gate_a2 & gate_b2);
    d2_q2 <= d2_q1;
  end

  always_comb begin
    gate_y1 = r_dly ? d1_q2 : r_tt[{gate_a1, gate_b1}];
    gate_y2 = d2_q2;
  end

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];   // {pass, err_count, err_mask}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a combinational gate with truth table tt mismatches exactly where it differs from TRUTH.
  function automatic logic [7:0] model(input logic [3:0] tt);
    logic [3:0] m;
    int c;
    m = tt ^ TT_NAND;
    c = 0;
    for (int k = 0; k < 4; k++) c += m[k];
    return {(m == 4'b0000), 3'(c), m};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_sweep(input logic [3:0] tt, input string name);
    int waited;
    logic [7:0] exp;
    r_tt  = tt;
    r_dly = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    chk({name, "_busy"}, busy1, 1);
    for (int k = 0; k < 4; k++) begin
      chk({name, "_vec"}, {gate_a1, gate_b1}, k);
      @(negedge clk);
    end
    waited = 0;
    while (!done1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk({name, "_done_lat"}, waited, 0);
    chk({name, "_busy_end"}, busy1, 0);
    exp = exp_q.pop_front();
    chk({name, "_result"}, {pass1, err_count1, err_mask1}, exp);
    @(negedge clk);
    chk({name, "_done_pulse"}, done1, 0);
  endtask

  task automatic wait_idle1();
    int w;
    w = 0;
    while ((busy1 || done1) && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("drain_bound", (w < 40), 1);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic [3:0] tt;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [3:0] tt;
    int pulses, first_at, last_at, w;
    logic [7:0] held;

    tbl[0] = '{"nand", 4'b0111, {1'b1, 3'd0, 4'b0000}};
    tbl[1] = '{"and",  4'b1000, {1'b0, 3'd4, 4'b1111}};
    tbl[2] = '{"tie1", 4'b1111, {1'b0, 3'd1, 4'b1000}};
    tbl[3] = '{"tie0", 4'b0000, {1'b0, 3'd3, 4'b0111}};

    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; r_tt = TT_NAND; r_dly = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs1", {gate_a1, gate_b1, busy1, done1, pass1, err_mask1, err_count1}, 0);
    chk("rst_state1", dbg_state1, 0);
    chk("rst_outs2", {gate_a2, gate_b2, busy2, done2, pass2, err_mask2, err_count2}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_quiet", {busy1, done1, gate_a1, gate_b1}, 0);

    // table-driven sweeps
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(tbl[i].exp);
      run_sweep(tbl[i].tt, tbl[i].name);
    end

    // results hold between sweeps (last table entry left 0111 / 3 / fail)
    held = {pass1, err_count1, err_mask1};
    repeat (5) @(negedge clk);
    chk("hold_results", {pass1, err_count1, err_mask1}, {1'b0, 3'd3, 4'b0111});
    chk("hold_stable", {pass1, err_count1, err_mask1}, held);

    // random gate behaviours against the truth-table model
    for (int i = 0; i < 10; i++) begin
      tt = 4'($urandom_range(0, 15));
      exp_q.push_back(model(tt));
      run_sweep(tt, "rand");
    end

    // delayed NAND with SETTLE=1 samples stale outputs
    r_dly = 1'b1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    w = 0;
    while (!done1 && w < 20) begin @(negedge clk); w++; end
    chk("dly_s1_lat", w, 4);
    chk("dly_s1_pass", pass1, 0);
    chk("dly_s1_mask_nz", (err_mask1 != 4'b0000), 1);
    r_dly = 1'b0;
    wait_idle1();

    // delayed NAND with SETTLE=3: done 12 cycles after accept, clean pass
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    chk("s3_busy", busy2, 1);
    w = 0;
    while (!done2 && w < 40) begin
      @(negedge clk);
      w++;
      if (w == 3) chk("s3_vec0_held", {gate_a2, gate_b2}, 1);
    end
    chk("s3_done_lat", w, 12);
    chk("s3_result", {pass2, err_count2, err_mask2}, {1'b1, 3'd0, 4'b0000});
    @(negedge clk);
    chk("s3_done_pulse", done2, 0);

    // mid-sweep start toggle must not restart the sweep
    r_tt = TT_NAND;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    chk("toggle_vec", {gate_a1, gate_b1}, 2);
    @(negedge clk);
    @(negedge clk);
    chk("toggle_done", done1, 1);
    @(negedge clk);

    // start held high: one done every 6 cycles
    start1 = 1'b1;
    pulses = 0; first_at = -1; last_at = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done1) begin
        pulses++;
        if (first_at < 0) first_at = i;
        last_at = i;
      end
    end
    start1 = 1'b0;
    chk("held_pulses", pulses, 3);
    chk("held_first", first_at, 5);
    chk("held_last", last_at, 17);
    wait_idle1();

    // asynchronous reset mid-sweep at idx=2
    r_tt = TT_NAND;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_vec", {gate_a1, gate_b1}, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_clear", {gate_a1, gate_b1, busy1, done1, pass1, err_mask1, err_count1}, 0);
    chk("rst_mid_state", dbg_state1, 0);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done1 || busy1) pulses++;
    end
    chk("rst_mid_silent", pulses, 0);
    exp_q.push_back(model(TT_NAND));
    run_sweep(TT_NAND, "post_rst");

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Sequencer that exhaustively exercises one 2-input combinational gate (the NAND/AND/OR/XOR cells in this library) in hardware. On `start` it drives the four input vectors 00, 01, 10, 11 onto the gate, waits a programmable settle time per vector, samples the gate output and compares it against a parameterised truth table. It then reports pass/fail, a per-vector error mask and an error count. It sits between a gate instance and a top-level self-test/status register.

## Interface
Parameters:
- `TRUTH`, default 4'b0111 (NAND): expected output; bit index = {a,b}, so TRUTH[0]=expected y for a=0,b=0 and TRUTH[3]=expected y for a=1,b=1
- `SETTLE`, default 1: clock cycles each vector is held before sampling; legal range 1..15

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level, sampled in IDLE only; begins a sweep
- `gate_y`  in  1  output of gate under test
- `gate_a`  out  1  gate input a (registered)
- `gate_b`  out  1  gate input b (registered)
- `busy`  out  1  high while a sweep is in progress
- `done`  out  1  one-cycle pulse at sweep end
- `pass`  out  1  1 when last sweep had zero mismatches; held until next start
- `err_mask`  out  4  bit k set if vector k ({a,b}=k) mismatched; held
- `err_count`  out  3  number of mismatching vectors, 0..4; held

## Operation
- States: IDLE, HOLD, FIN.
- Registers: 2-bit vector index `idx`, 4-bit settle counter `cnt`.
- IDLE:
  - gate_a=gate_b=0, busy=0.
  - If start=1 at an edge: idx<=0, cnt<=SETTLE-1, {gate_a,gate_b}<=2'b00, err_mask<=0, err_count<=0, pass<=0, busy<=1, go to HOLD.
- HOLD:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: compare gate_y with TRUTH[idx]. On mismatch, set err_mask[idx] and increment err_count. An X/Z on gate_y counts as a mismatch in simulation (case-inequality compare).
  - Then, if idx!=3: idx<=idx+1, {gate_a,gate_b}<=idx+1, cnt<=SETTLE-1, stay in HOLD.
  - If idx==3: gate_a=gate_b<=0, busy<=0, done<=1, and pass<=1 iff no mismatch including this final vector. Go to FIN.
- FIN: done<=0, go to IDLE. start is ignored in FIN.
- start is ignored while busy=1. If start is held high continuously, a new sweep begins at the first IDLE edge, so back-to-back sweeps are separated by one FIN cycle.
- err_count saturates naturally at 4; no wrap is possible.

## Timing
- Reset (rst_n=0, asynchronous, any state including mid-sweep): state=IDLE, idx=0, cnt=0, gate_a=gate_b=0, busy=0, done=0, pass=0, err_mask=4'b0000, err_count=3'd0. An interrupted sweep reports nothing.
- Let E0 be the edge where start is accepted. Vector k is driven from edge E0+k·SETTLE and sampled at edge E0+(k+1)·SETTLE.
- The gate therefore has SETTLE−1 full cycles plus one cycle of combinational time before each sample.
- busy is high from E0 to E0+4·SETTLE.
- done is high for exactly the cycle following edge E0+4·SETTLE.
- pass, err_mask and err_count are valid in the same cycle as done, and stable until the next accepted start.
- Minimum sweep-to-sweep period: 4·SETTLE+2 cycles.

## Test plan
- NAND gate, TRUTH=4'b0111, SETTLE=1; pulse start → gate_{a,b} steps 00,01,10,11 on consecutive cycles; done one cycle after the 4th edge; pass=1, err_mask=0000, err_count=0.
- AND gate substituted, TRUTH=4'b0111 → all four mismatch: pass=0, err_mask=1111, err_count=4.
- gate_y tied to 1, TRUTH=4'b0111 → err_mask=1000, err_count=1, pass=0. gate_y tied to 0 → err_mask=0111, err_count=3.
- NAND with output delayed 2 clock cycles: SETTLE=3 → pass=1 and done 12 cycles after E0. SETTLE=1 → pass=0, err_mask≠0000.
- start held high for 20 cycles, SETTLE=1 → exactly one done pulse per 6 cycles; mid-sweep start toggles do not restart idx. Outputs hold between sweeps.
- rst_n low for 1 cycle while idx=2 → immediate asynchronous clear of all outputs to reset values, no done pulse; the next start runs a full clean sweep with pass=1 for NAND.
